mempool_tile_resp_buffer: RTL and testbench
===========================================

# mempool_tile_resp_buffer

Per-bank response buffer between an SRAM bank and the tile response arbiter. It accepts bank requests under credit control, tracks in-flight accesses through a fixed-latency delay line, and captures each bank read result with its metadata into a small FIFO. The FIFO presents responses to one arbiter input as a valid/ready stream. One instance per bank; all `resp_*` outputs of all instances form the arbiter's `data_i`/`valid_i`/`ready_o` vectors.

## Interface
Clock is `clk_i`; reset is `rst_ni`, synchronous, active-low.

Parameters:
- `Depth`, 4: response FIFO entries, which is also the credit limit; must be ≥ 1.
- `BankLatency`, 1: cycles from `bank_req_o` to valid `bank_rdata_i`; must be ≥ 1.
- `meta_t`, logic: request metadata (initiator id, tag) returned with the data.
- `data_t`, logic: bank read data type.

Ports:
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: synchronous active-low reset.
- `req_valid_i` in, 1: bank access request from the request crossbar.
- `req_ready_o` out, 1: a credit is available; the request is accepted this cycle.
- `req_meta_i` in, `meta_t`: metadata to be returned with the response.
- `bank_req_o` out, 1: bank enable; equals `req_valid_i & req_ready_o`.
- `bank_rdata_i` in, `data_t`: bank data, valid `BankLatency` cycles after `bank_req_o`.
- `resp_valid_o` out, 1: head FIFO entry valid (to arbiter `valid_i[b]`).
- `resp_ready_i` in, 1: arbiter accepts the head entry (arbiter `ready_o[b]`).
- `resp_meta_o` out, `meta_t`: head entry metadata.
- `resp_data_o` out, `data_t`: head entry data.
- `occupancy_o` out, `$clog2(Depth+1)`: current `outstanding_q`.

## Operation
- Accept: `acc = req_valid_i & req_ready_o`. On accept, `bank_req_o = 1` in the same cycle. Meta and a valid bit enter the delay line at stage 0.
- Delay line: `BankLatency` register stages carrying `{vld, meta}`. The last stage's `vld` marks the cycle in which `bank_rdata_i` is sampled.
- Capture: when the last stage is valid, `{meta, bank_rdata_i}` is written to the FIFO tail at the clock edge.
- FIFO:
  - Circular buffer with read and write pointers that wrap at `Depth`, plus an entry count.
  - No fall-through; outputs come from storage.
  - `resp_valid_o = count != 0`.
  - Pop when `resp_valid_o & resp_ready_i`.
- Credits: `outstanding_q` counts accepted requests not yet popped.
  - Increments on accept; decrements on pop; unchanged when both or neither occur.
  - `req_ready_o = rst_ni & (outstanding_q < Depth)`. This is registered state only; there is no combinational path from `resp_ready_i`.
  - `outstanding_q ≤ Depth` always, so the FIFO cannot overflow. An overflow write is an assertion failure.
- Simultaneous push and pop on the FIFO is legal, including when full (count = Depth) and when empty. On empty, the pushed entry becomes visible next cycle.
- Order: responses leave in acceptance order.
- The stream contract holds: while `resp_valid_o` is high and not accepted, `resp_meta_o`/`resp_data_o` stay stable and valid stays high.

## Timing
- Reset values: `resp_valid_o = 0`, `bank_req_o = 0`, `occupancy_o = 0`, all pointers and delay-line valid bits 0.
  - `req_ready_o` is 0 while `rst_ni` is low and 1 in the first cycle after release.
  - Data and meta registers are not reset.
- Latency:
  - A request accepted in cycle t is sampled from the bank in cycle t+`BankLatency`.
  - `resp_valid_o` rises in cycle t+`BankLatency`+1 if the FIFO was empty.
- Credit return: a pop in cycle p frees a credit visible in cycle p+1.
- Throughput: one response per cycle sustained requires `Depth ≥ BankLatency+2`. Smaller values are legal but cause bubbles.
- Reset mid-operation:
  - All delay-line and FIFO contents are discarded.
  - Bank data arriving after reset for pre-reset requests is ignored, because the delay-line valid bits are cleared.
  - The counter is zeroed.

## Test plan
- Single read, `BankLatency`=1, `Depth`=4, `resp_ready_i`=1:
  - Accept in cycle 0 with meta 0x3 and `bank_rdata_i`=0xAB in cycle 1.
  - Required: `resp_valid_o`=1 in cycle 2 with meta 0x3 / data 0xAB; it drops in cycle 3; `occupancy_o` back to 0 in cycle 3.
- Credit exhaustion, `resp_ready_i`=0, continuous `req_valid_i`:
  - Required: exactly 4 accepts in cycles 0–3; `req_ready_o`=0 from cycle 4; `occupancy_o`=4.
  - Then one pop in cycle k: `req_ready_o`=1 in cycle k+1 only.
- Streaming with `Depth`=3, `BankLatency`=1, `resp_ready_i`=1, 20 back-to-back requests:
  - Required: 20 responses in order, one per cycle after the 2-cycle fill.
- Random `resp_ready_i` backpressure (50%), 1000 requests, `Depth`=4, `BankLatency`=2:
  - Required: meta/data order and values match a scoreboard.
  - Stability while stalled; `occupancy_o` never exceeds 4; no overflow assertion.
- Simultaneous push and pop at count = `Depth` and at count = 0:
  - Required: count unchanged or incremented, respectively.
  - Pointers wrap correctly after 2·`Depth` operations.
- Reset asserted with 2 requests in the delay line and 2 FIFO entries:
  - Required: `resp_valid_o`=0 and `req_ready_o`=0 during reset; `occupancy_o`=0 after reset.
  - Late bank data is not captured, and `resp_valid_o` stays 0 until a new request completes.

Source files
------------

// File: rtl/mempool_tile_resp_buffer.sv
// mempool_tile_resp_buffer: per-bank response buffer. Accepts bank requests
// under credit control, tracks in-flight accesses through a fixed-latency
// delay line and queues bank read results with their metadata in a FIFO
// that feeds one input of the tile response arbiter.
module mempool_tile_resp_buffer #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned BankLatency = 1,
  parameter type         meta_t      = logic,
  parameter type         data_t      = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  meta_t                      req_meta_i,
  output logic                       bank_req_o,
  input  data_t                      bank_rdata_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output meta_t                      resp_meta_o,
  output data_t                      resp_data_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    meta_t meta;
    data_t data;
  } entry_t;

  logic [BankLatency-1:0] dl_vld_q, dl_vld_d;
  meta_t                  dl_meta_q [BankLatency];
  meta_t                  dl_meta_d [BankLatency];
  entry_t                 mem_q [Depth];
  entry_t                 mem_d [Depth];
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [CntW-1:0]        outstanding_q, outstanding_d;
  logic                   acc, push, pop;

  // Credits come from registered state only; reset forces no acceptance.
  assign req_ready_o  = rst_ni & (outstanding_q < CntW'(Depth));
  assign acc          = req_valid_i & req_ready_o;
  assign bank_req_o   = acc;
  assign push         = dl_vld_q[BankLatency-1];
  assign resp_valid_o = (count_q != '0);
  assign pop          = resp_valid_o & resp_ready_i;
  assign resp_meta_o  = mem_q[rptr_q].meta;
  assign resp_data_o  = mem_q[rptr_q].data;
  assign occupancy_o  = outstanding_q;

  // Delay line: a new access enters stage 0, older ones shift one stage per cycle
  always_comb begin
    dl_vld_d     = '0;
    dl_meta_d    = dl_meta_q;
    dl_vld_d[0]  = acc;
    dl_meta_d[0] = req_meta_i;
    for (int unsigned i = 1; i < BankLatency; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_meta_d[i] = dl_meta_q[i-1];
    end
  end

  // FIFO: capture bank data at the tail when the last stage is valid, pop the head
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = {dl_meta_q[BankLatency-1], bank_rdata_i};
      wptr_d        = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Credit counter: accepted requests not yet popped
  always_comb begin
    case ({acc, pop})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state with synchronous reset; in-flight valid bits are dropped
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dl_vld_q      <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      dl_vld_q      <= dl_vld_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Payload storage is not reset; validity is tracked by the control state
  always_ff @(posedge clk_i) begin
    dl_meta_q <= dl_meta_d;
    mem_q     <= mem_d;
  end

  // Credits bound the FIFO fill, so a write into a full FIFO without a pop is a bug
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push && !pop && (count_q == CntW'(Depth))));

endmodule

// File: tb/tb_mempool_tile_resp_buffer.sv
// tb_mempool_tile_resp_buffer: directed checks on three configurations
// (Depth/BankLatency = 4/1, 3/1, 4/2) with a simple fixed-latency bank model
// returning data = meta ^ 8'hA8 for each accepted request.
module tb_mempool_tile_resp_buffer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Instance a: Depth 4, BankLatency 1
  logic       a_valid  = 1'b0;
  logic       a_rready = 1'b0;
  logic [7:0] a_meta   = 8'h00;
  logic       a_ready, a_breq, a_rvalid;
  logic [7:0] a_rdata, a_rmeta, a_rdat;
  logic [2:0] a_occ;
  logic       a_bv;
  logic [7:0] a_bm;

  // Instance s: Depth 3, BankLatency 1
  logic       s_valid  = 1'b0;
  logic       s_rready = 1'b0;
  logic [7:0] s_meta   = 8'h00;
  logic       s_ready, s_breq, s_rvalid;
  logic [7:0] s_rdata, s_rmeta, s_rdat;
  logic [1:0] s_occ;
  logic       s_bv;
  logic [7:0] s_bm;

  // Instance r: Depth 4, BankLatency 2
  logic       r_valid  = 1'b0;
  logic       r_rready = 1'b0;
  logic [7:0] r_meta   = 8'h00;
  logic       r_ready, r_breq, r_rvalid;
  logic [7:0] r_rdata, r_rmeta, r_rdat;
  logic [2:0] r_occ;
  logic       r_bv1, r_bv2;
  logic [7:0] r_bm1, r_bm2;

  mempool_tile_resp_buffer #(.Depth(4), .BankLatency(1),
    .meta_t(logic [7:0]), .data_t(logic [7:0])) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_meta_i(a_meta), .bank_req_o(a_breq), .bank_rdata_i(a_rdata),
    .resp_valid_o(a_rvalid), .resp_ready_i(a_rready), .resp_meta_o(a_rmeta),
    .resp_data_o(a_rdat), .occupancy_o(a_occ));

  mempool_tile_resp_buffer #(.Depth(3), .BankLatency(1),
    .meta_t(logic [7:0]), .data_t(logic [7:0])) u_s (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(s_valid), .req_ready_o(s_ready),
    .req_meta_i(s_meta), .bank_req_o(s_breq), .bank_rdata_i(s_rdata),
    .resp_valid_o(s_rvalid), .resp_ready_i(s_rready), .resp_meta_o(s_rmeta),
    .resp_data_o(s_rdat), .occupancy_o(s_occ));

  mempool_tile_resp_buffer #(.Depth(4), .BankLatency(2),
    .meta_t(logic [7:0]), .data_t(logic [7:0])) u_r (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(r_valid), .req_ready_o(r_ready),
    .req_meta_i(r_meta), .bank_req_o(r_breq), .bank_rdata_i(r_rdata),
    .resp_valid_o(r_rvalid), .resp_ready_i(r_rready), .resp_meta_o(r_rmeta),
    .resp_data_o(r_rdat), .occupancy_o(r_occ));

  // Bank models: read data appears BankLatency cycles after the bank request
  always @(posedge clk) begin
    a_bv  <= a_breq;
    a_bm  <= a_meta;
    s_bv  <= s_breq;
    s_bm  <= s_meta;
    r_bv1 <= r_breq;
    r_bm1 <= r_meta;
    r_bv2 <= r_bv1;
    r_bm2 <= r_bm1;
  end
  assign a_rdata = (a_bv === 1'b1)  ? (a_bm ^ 8'hA8)  : 8'hEE;
  assign s_rdata = (s_bv === 1'b1)  ? (s_bm ^ 8'hA8)  : 8'hEE;
  assign r_rdata = (r_bv2 === 1'b1) ? (r_bm2 ^ 8'hA8) : 8'hEE;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_valid = 1'b1; s_valid = 1'b1; r_valid = 1'b1;
    tick; tick; #1;
    checks++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready got %0h exp 0", a_ready); else passes++;
    checks++; if (a_breq !== 1'b0) $display("FAIL rst_a_breq got %0h exp 0", a_breq); else passes++;
    checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %0h exp 0", s_ready); else passes++;
    checks++; if (r_breq !== 1'b0) $display("FAIL rst_r_breq got %0h exp 0", r_breq); else passes++;
    checks++; if (a_rvalid !== 1'b0) $display("FAIL rst_a_rvalid got %0h exp 0", a_rvalid); else passes++;
    checks++; if (a_occ !== 3'd0) $display("FAIL rst_a_occ got %0d exp 0", a_occ); else passes++;
    checks++; if (r_occ !== 3'd0) $display("FAIL rst_r_occ got %0d exp 0", r_occ); else passes++;
    a_valid = 1'b0; s_valid = 1'b0; r_valid = 1'b0;
    rst_n = 1'b1;
    tick; #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL rel_a_ready got %0h exp 1", a_ready); else passes++;
    checks++; if (s_ready !== 1'b1) $display("FAIL rel_s_ready got %0h exp 1", s_ready); else passes++;
    checks++; if (r_ready !== 1'b1) $display("FAIL rel_r_ready got %0h exp 1", r_ready); else passes++;
    checks++; if (a_rvalid !== 1'b0) $display("FAIL rel_a_rvalid got %0h exp 0", a_rvalid); else passes++;
    tick;
  endtask

  task automatic test_single;
    a_valid = 1'b1; a_meta = 8'h03; a_rready = 1'b1;
    #1;
    checks++; if (a_breq !== 1'b1) $display("FAIL single_accept got %0h exp 1", a_breq); else passes++;
    tick;
    a_valid = 1'b0;
    #1;
    checks++; if (a_rvalid !== 1'b0) $display("FAIL single_c1_valid got %0h exp 0", a_rvalid); else passes++;
    checks++; if (a_occ !== 3'd1) $display("FAIL single_c1_occ got %0d exp 1", a_occ); else passes++;
    tick; #1;
    checks++;
    if ({a_rvalid, a_rmeta, a_rdat} !== {1'b1, 8'h03, 8'hAB})
      $display("FAIL single_c2_resp got %0h/%0h/%0h exp 1/03/ab", a_rvalid, a_rmeta, a_rdat);
    else passes++;
    tick; #1;
    checks++; if (a_rvalid !== 1'b0) $display("FAIL single_c3_valid got %0h exp 0", a_rvalid); else passes++;
    checks++; if (a_occ !== 3'd0) $display("FAIL single_c3_occ got %0d exp 0", a_occ); else passes++;
    tick;
  endtask

  // Pop n responses from instance a expecting metas first, first+1, ...
  task automatic drain_a(input logic [7:0] first, input int n);
    int idx;
    logic [7:0] m;
    idx = 0;
    a_valid = 1'b0; a_rready = 1'b1;
    for (int c = 0; c < 20 && idx < n; c++) begin
      #1;
      if (a_rvalid === 1'b1) begin
        m = 8'(first + 8'(idx));
        checks++;
        if ({a_rmeta, a_rdat} !== {m, m ^ 8'hA8})
          $display("FAIL drain_resp got %0h/%0h exp %0h/%0h", a_rmeta, a_rdat, m, m ^ 8'hA8);
        else passes++;
        idx++;
      end
      tick;
    end
    checks++; if (idx != n) $display("FAIL drain_count got %0d exp %0d", idx, n); else passes++;
    #1;
    checks++; if (a_occ !== 3'd0) $display("FAIL drain_occ got %0d exp 0", a_occ); else passes++;
    a_rready = 1'b0;
    tick;
  endtask

  task automatic test_credit;
    int acc;
    acc = 0;
    a_rready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_meta = 8'(8'h10 + 8'(i));
      #1;
      checks++;
      if (a_ready !== (i < 4)) $display("FAIL credit_ready c%0d got %0h exp %0h", i, a_ready, (i < 4));
      else passes++;
      if (a_breq === 1'b1) acc++;
      tick;
    end
    checks++; if (acc != 4) $display("FAIL credit_accepts got %0d exp 4", acc); else passes++;
    a_rready = 1'b1;
    #1;
    checks++; if (a_occ !== 3'd4) $display("FAIL credit_occ got %0d exp 4", a_occ); else passes++;
    checks++; if (a_ready !== 1'b0) $display("FAIL credit_popcyc_ready got %0h exp 0", a_ready); else passes++;
    checks++;
    if ({a_rvalid, a_rmeta} !== {1'b1, 8'h10})
      $display("FAIL credit_head got %0h/%0h exp 1/10", a_rvalid, a_rmeta);
    else passes++;
    tick;
    a_rready = 1'b0; a_meta = 8'h14;
    #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL credit_return got %0h exp 1", a_ready); else passes++;
    checks++; if (a_rmeta !== 8'h11) $display("FAIL credit_next_head got %0h exp 11", a_rmeta); else passes++;
    tick;
    a_valid = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) $display("FAIL credit_reexhaust got %0h exp 0", a_ready); else passes++;
    tick;
    drain_a(8'h11, 4);
  endtask

  task automatic test_simul;
    logic [7:0] m;
    a_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_meta = 8'(8'h20 + 8'(i));
      #1;
      checks++; if (a_breq !== 1'b1) $display("FAIL simul_fill c%0d got %0h exp 1", i, a_breq); else passes++;
      tick;
    end
    for (int j = 0; j < 8; j++) begin
      a_valid = 1'b1; a_rready = 1'b1; a_meta = 8'(8'h23 + 8'(j));
      m = 8'(8'h20 + 8'(j));
      #1;
      checks++; if (a_occ !== 3'd3) $display("FAIL simul_occ j%0d got %0d exp 3", j, a_occ); else passes++;
      checks++; if (a_breq !== 1'b1) $display("FAIL simul_accept j%0d got %0h exp 1", j, a_breq); else passes++;
      checks++;
      if ({a_rvalid, a_rmeta, a_rdat} !== {1'b1, m, m ^ 8'hA8})
        $display("FAIL simul_head j%0d got %0h/%0h/%0h exp 1/%0h/%0h", j, a_rvalid, a_rmeta, a_rdat, m, m ^ 8'hA8);
      else passes++;
      tick;
    end
    drain_a(8'h28, 3);
  endtask

  task automatic test_stream;
    logic [7:0] m;
    logic       exp_v;
    s_rready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      s_valid = (c < 20); s_meta = 8'(8'h40 + 8'(c));
      #1;
      if (c < 20) begin
        checks++; if (s_breq !== 1'b1) $display("FAIL stream_accept c%0d got %0h exp 1", c, s_breq); else passes++;
      end
      exp_v = (c >= 2) && (c < 22);
      checks++; if (s_rvalid !== exp_v) $display("FAIL stream_valid c%0d got %0h exp %0h", c, s_rvalid, exp_v); else passes++;
      if (exp_v) begin
        m = 8'(8'h40 + 8'(c) - 8'd2);
        checks++;
        if ({s_rmeta, s_rdat} !== {m, m ^ 8'hA8})
          $display("FAIL stream_resp c%0d got %0h/%0h exp %0h/%0h", c, s_rmeta, s_rdat, m, m ^ 8'hA8);
        else passes++;
      end
      tick;
    end
    s_valid = 1'b0; s_rready = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0]  q[$];
    logic [7:0]  m;
    logic        stalled;
    logic [15:0] held;
    int          sent, cyc;
    sent = 0; cyc = 0; stalled = 1'b0; held = '0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      r_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      r_meta   = 8'($urandom);
      r_rready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        checks++;
        if ({r_rvalid, r_rmeta, r_rdat} !== {1'b1, held})
          $display("FAIL rand_stall got %0h/%0h/%0h exp 1/%0h", r_rvalid, r_rmeta, r_rdat, held);
        else passes++;
      end
      checks++; if (r_occ > 3'd4) $display("FAIL rand_occ got %0d exp <=4", r_occ); else passes++;
      if (r_breq === 1'b1) begin
        q.push_back(r_meta);
        sent++;
      end
      if (r_rvalid === 1'b1 && r_rready) begin
        checks++;
        if (q.size() == 0) $display("FAIL rand_spurious got %0h exp none", r_rmeta);
        else begin
          m = q.pop_front();
          if ({r_rmeta, r_rdat} !== {m, m ^ 8'hA8})
            $display("FAIL rand_resp got %0h/%0h exp %0h/%0h", r_rmeta, r_rdat, m, m ^ 8'hA8);
          else passes++;
        end
      end
      stalled = (r_rvalid === 1'b1) && !r_rready;
      held    = {r_rmeta, r_rdat};
      cyc++;
      tick;
    end
    checks++;
    if (sent != 1000 || q.size() != 0) $display("FAIL rand_done got %0d/%0d exp 1000/0", sent, q.size());
    else passes++;
    r_valid = 1'b0; r_rready = 1'b0;
  endtask

  task automatic test_reset_mid;
    r_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1; r_meta = 8'(8'h60 + 8'(i));
      #1;
      checks++; if (r_breq !== 1'b1) $display("FAIL rmid_fill c%0d got %0h exp 1", i, r_breq); else passes++;
      tick;
    end
    r_valid = 1'b1; rst_n = 1'b0;
    #1;
    checks++; if (r_ready !== 1'b0) $display("FAIL rmid_ready got %0h exp 0", r_ready); else passes++;
    checks++; if (r_breq !== 1'b0) $display("FAIL rmid_breq got %0h exp 0", r_breq); else passes++;
    checks++; if (r_occ !== 3'd4) $display("FAIL rmid_pre_occ got %0d exp 4", r_occ); else passes++;
    checks++; if (r_rvalid !== 1'b1) $display("FAIL rmid_pre_valid got %0h exp 1", r_rvalid); else passes++;
    tick;
    rst_n = 1'b1; r_valid = 1'b0; r_rready = 1'b1;
    #1;
    checks++; if (r_rvalid !== 1'b0) $display("FAIL rmid_post_valid got %0h exp 0", r_rvalid); else passes++;
    checks++; if (r_occ !== 3'd0) $display("FAIL rmid_post_occ got %0d exp 0", r_occ); else passes++;
    checks++; if (r_ready !== 1'b1) $display("FAIL rmid_post_ready got %0h exp 1", r_ready); else passes++;
    tick;
    for (int c = 6; c < 10; c++) begin
      #1;
      checks++; if (r_rvalid !== 1'b0) $display("FAIL rmid_late c%0d got %0h exp 0", c, r_rvalid); else passes++;
      tick;
    end
    r_valid = 1'b1; r_meta = 8'h77;
    #1;
    checks++; if (r_breq !== 1'b1) $display("FAIL rmid_new_accept got %0h exp 1", r_breq); else passes++;
    tick;
    r_valid = 1'b0;
    for (int c = 11; c < 13; c++) begin
      #1;
      checks++; if (r_rvalid !== 1'b0) $display("FAIL rmid_wait c%0d got %0h exp 0", c, r_rvalid); else passes++;
      tick;
    end
    #1;
    checks++;
    if ({r_rvalid, r_rmeta, r_rdat} !== {1'b1, 8'h77, 8'hDF})
      $display("FAIL rmid_new_resp got %0h/%0h/%0h exp 1/77/df", r_rvalid, r_rmeta, r_rdat);
    else passes++;
    tick; #1;
    checks++; if (r_occ !== 3'd0) $display("FAIL rmid_final_occ got %0d exp 0", r_occ); else passes++;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_credit;
    test_simul;
    test_stream;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
